// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
//   Sequencing controller for the convolution datapath (X memory, F memory,
//   multiplier, accumulator). Once both operand memories are loaded (start),
//   it walks the synchronous-read memory addresses for each output j, drives
//   the accumulator clear/enable, presents the result on a valid/ready
//   handshake, and pulses done after the last output is accepted.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high
//   start         both memories full; only sampled in IDLE
//   m_ready_y     downstream accepts the current output
//   xmem_rd_addr  X memory read address (j+k)
//   fmem_rd_addr  F memory read address (k)
//   acc_clr       accumulator clear (priority over acc_en)
//   acc_en        accumulator loads acc + x*f
//   m_valid_y     accumulator holds a valid output
//   out_idx       index j of the current output
//   busy          controller is not idle
//   done          one-cycle pulse after the last output is accepted
//
// All outputs are decoded from registered state, j and k only (Moore).
// -----------------------------------------------------------------------------
module conv_seq_ctrl #(
  parameter  int X_SIZE   = 8,
  parameter  int F_SIZE   = 4,
  parameter  int X_ADDR_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
  parameter  int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1,
  localparam int Y_SIZE   = X_SIZE - F_SIZE + 1,
  localparam int Y_IDX_W  = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                m_ready_y,
  output logic [X_ADDR_W-1:0] xmem_rd_addr,
  output logic [F_ADDR_W-1:0] fmem_rd_addr,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                m_valid_y,
  output logic [Y_IDX_W-1:0]  out_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [F_ADDR_W-1:0] K_LAST = F_ADDR_W'(F_SIZE - 1);
  localparam logic [Y_IDX_W-1:0]  J_LAST = Y_IDX_W'(Y_SIZE - 1);

  state_t               state_q, state_d;
  logic [Y_IDX_W-1:0]   j_q, j_d;
  logic [F_ADDR_W-1:0]  k_q, k_d;

  // Address of the current tap; j+k never exceeds X_SIZE-1, so no wrap.
  logic [X_ADDR_W-1:0]  x_addr;
  assign x_addr = X_ADDR_W'(j_q) + X_ADDR_W'(k_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      S_DRAIN: begin
        // k holds through DRAIN so the addresses keep their last values.
        k_d     = '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        // m_valid_y is 1 throughout OUT, so m_ready_y alone marks a transfer.
        if (m_ready_y) begin
          if (j_q == J_LAST) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        j_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        j_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    xmem_rd_addr = '0;
    fmem_rd_addr = '0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    m_valid_y    = 1'b0;
    done         = 1'b0;
    out_idx      = j_q;
    busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_ISSUE: begin
        xmem_rd_addr = x_addr;
        fmem_rd_addr = k_q;
        // First tap clears; later taps accumulate the data returned for the
        // previous cycle's address.
        acc_clr      = (k_q == '0);
        acc_en       = (k_q != '0);
      end
      S_DRAIN: begin
        xmem_rd_addr = x_addr;
        fmem_rd_addr = k_q;
        acc_en       = 1'b1;
      end
      S_OUT:   m_valid_y = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

endmodule
